anton_neopixel_stream_sequencer: RTL and testbench
==================================================

Name: anton_neopixel_stream_sequencer

Overview:
Next-generation NeoPixel bit-stream sequencer. It drives the sub-bit pattern, pixel-bit and pixel-index counters that the pattern generator and buffer read port consume, on the 6.4 MHz slow clock domain. It adds the following over the current stream logic:
- an explicit IDLE state
- one-shot and loop modes (regCtrlLoop)
- runtime 24-bit RGB or 32-bit RGBW pixels
- parametrised sub-bit count
- clamped software limit
- pause on run deassert
- a streamDone pulse
- a synchronous reset

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last valid buffer byte address.
RESET_DELAY, `RESET_DELAY_DEFAULT, number of clk6_4mhz cycles spent in RESET (must be ≥2).
SUBBITS, 8, sub-bit pattern steps per data bit (must be ≥2).
BUFFER_BITS, `CLOG2(BUFFER_END+1), localparam.
PATTERN_BITS, `CLOG2(SUBBITS), localparam.
RESET_BITS, `CLOG2(RESET_DELAY+1), localparam.

Ports:
clk6_4mhz  in  1  slow stream clock.
reset  in  1  synchronous active-high reset.
regCtrlInit  in  1  holds the block inactive; stream outputs forced 0.
regCtrlRun  in  1  run enable; low = pause.
regCtrlLoop  in  1  1 = restart after RESET; 0 = one-shot.
regCtrlLimit  in  1  use regMax as the last index.
regCtrl32bit  in  1  pixel index steps by 4.
regCtrlRgbw  in  1  32 bits per pixel (else 24).
regMax  in  13  software last index.
initSlow  in  1  one-cycle counter/state clear request.
initSlowDone  out  1  pulse one cycle after initSlow.
bitPatternIndex  out  PATTERN_BITS  sub-bit step.
pixelBitIndex  out  5  bit within pixel.
pixelIndex  out  BUFFER_BITS  current pixel byte address.
pixelIndexMax  out  BUFFER_BITS  effective last index.
state  out  2  `ENUM_STATE_IDLE=0, TRANSMIT=1, RESET=2.
streamOutput  out  1  transmitting a data bit.
streamReset  out  1  line held low for reset.
streamBitOf  out  1  last sub-step of the last bit of a pixel.
streamPixelOf  out  1  streamBitOf on the last pixel.
streamSyncOf  out  1  last RESET cycle.
streamDone  out  1  one-shot frame complete pulse.

Behaviour:
- **Reset:** on reset (highest priority) all counters are 0, state=IDLE, initSlowDone=0, armed=1. All stream outputs are 0.
- **Activity gating:**
  - active = regCtrlRun && !regCtrlInit.
  - streamOutput = active && state==TRANSMIT.
  - streamReset = active && state==RESET.
  - When inactive, all counters hold (pause). Resuming continues from the exact held position.
- **IDLE:**
  - If active && armed, go to TRANSMIT next cycle with all counters 0, latching bitsPerPixel = regCtrlRgbw ? 32 : 24.
  - armed is cleared on streamDone and set while regCtrlRun==0. A new one-shot frame therefore needs Run to go low then high.
- **TRANSMIT counters:**
  - bitPatternIndex increments when streamOutput and wraps at SUBBITS-1. patternOf = streamOutput && bitPatternIndex==SUBBITS-1.
  - On patternOf, pixelBitIndex increments and wraps at bitsPerPixel-1. streamBitOf = patternOf && pixelBitIndex==bitsPerPixel-1.
- **Effective limit:** pixelIndexMax = regCtrlLimit ? min(regMax, BUFFER_END) : BUFFER_END. The compare uses 13-bit width, so no truncation.
- **Last pixel:** step = regCtrl32bit ? 4 : 1. last = (pixelIndex + step) > pixelIndexMax, evaluated at BUFFER_BITS+1 width. streamPixelOf = streamBitOf && last.
- **Pixel advance:** on streamBitOf && !last, pixelIndex += step.
- **End of frame:** on streamPixelOf, pixelIndex=0, resetCount=0, state=RESET. Counters are already 0 at this point through their wraps.
- **RESET:**
  - resetCount increments when streamReset.
  - streamSyncOf = streamReset && resetCount==RESET_DELAY-1, giving exactly RESET_DELAY active cycles.
  - On streamSyncOf, resetCount=0. If regCtrlLoop, state=TRANSMIT and bitsPerPixel is re-latched. Otherwise state=IDLE and streamDone=1 for one cycle (registered, same edge).
- **Mode latching:** regCtrl32bit and regCtrlLimit are live. regCtrlRgbw changes take effect only at frame start.
- **initSlow** (priority below reset, above all else): clears all counters, state=IDLE, armed=1. initSlowDone=1 on the next cycle, then 0.
- **Simulation:** no $finish or simulation-only constructs.

Decomposition:
- anton_common.vh gains `ENUM_STATE_IDLE/TRANSMIT/RESET` (2-bit) and `SUBBITS_DEFAULT`; existing default macros are reused.
- One sub-module, anton_neopixel_reset_timer:
  - Inputs: clk6_4mhz, reset, clear, enable.
  - Output: syncOf.
  - Parameter: RESET_DELAY.
  - Owns resetCount.

Test Plan:
1. BUFFER_END=3, SUBBITS=8, RESET_DELAY=16, loop=0, Run 0→1 → TRANSMIT 1 cycle later; pixelIndex 0,1,2,3 with 192 cycles each; streamPixelOf at TRANSMIT cycle 768; 16 RESET cycles; streamDone one pulse; IDLE; holding Run high does not restart.
2. regCtrlRgbw=1 → pixelBitIndex reaches 31; streamBitOf every 256 cycles; frame = 1024 cycles.
3. BUFFER_END=15, regCtrl32bit=1, Limit=1, regMax=8 → indices 0,4,8 then RESET. With regMax=100 → 0,4,8,12 (clamped to 15).
4. loop=1 → after streamSyncOf, TRANSMIT resumes at pixel 0 the next cycle; no streamDone; state never IDLE across 3 frames.
5. Run dropped for 10 cycles at pixel 2, bit 5, step 3 → outputs 0, counters frozen; resume continues at step 4; total frame length +0 active cycles.
6. reset asserted mid-RESET and initSlow mid-TRANSMIT → all counters 0 and state IDLE next cycle; initSlowDone high exactly one cycle after initSlow.

Source files
------------

// File: rtl/anton_neopixel_stream_sequencer_pkg.sv
// Shared types and defaults for the NeoPixel stream sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package anton_neopixel_stream_sequencer_pkg;

  localparam int BUFFER_END_DEFAULT  = 255;
  // 320 cycles at 6.4 MHz is 50 us of line-low latch time.
  localparam int RESET_DELAY_DEFAULT = 320;
  localparam int SUBBITS_DEFAULT     = 8;
  localparam int LIMIT_W             = 13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRANSMIT = 2'd1,
    ST_RESET    = 2'd2
  } state_e;

  // Index of the last data bit of a pixel: 24-bit RGB or 32-bit RGBW.
  function automatic logic [4:0] pixel_bit_last(input logic rgbw);
    return rgbw ? 5'd31 : 5'd23;
  endfunction

endpackage

// File: rtl/anton_neopixel_reset_timer.sv
// Counts the line-low latch period between frames; syncOf marks its last cycle.
// Latency: syncOf is combinational from the count and enable.
// Backpressure: the count holds whenever enable is low (stream paused).
// Ports: clk6_4mhz/reset (sync, active-high), clear (zero the count),
//        enable (advance one step), syncOf (last enabled latch cycle).
module anton_neopixel_reset_timer
  import anton_neopixel_stream_sequencer_pkg::*;
#(
  parameter int RESET_DELAY = RESET_DELAY_DEFAULT
) (
  input  logic clk6_4mhz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic syncOf
);

  localparam int RESET_BITS = $clog2(RESET_DELAY + 1);
  localparam logic [RESET_BITS-1:0] COUNT_LAST = RESET_BITS'(RESET_DELAY - 1);

  logic [RESET_BITS-1:0] r_reset_count;

  assign syncOf = enable && (r_reset_count == COUNT_LAST);

  always_ff @(posedge clk6_4mhz) begin
    if (reset || clear) begin
      r_reset_count <= '0;
    end else if (enable) begin
      r_reset_count <= syncOf ? '0 : r_reset_count + 1'b1;
    end
  end

endmodule

// File: rtl/anton_neopixel_stream_sequencer.sv
// Sequences sub-bit, pixel-bit and pixel-byte counters for the NeoPixel stream.
// Latency: IDLE->TRANSMIT one cycle after run; streamDone/initSlowDone registered.
// Backpressure: Run low or Init high freezes every counter in place (pause).
// Ports: clk6_4mhz/reset (sync, active-high); regCtrl* mode controls; regMax
//        software limit; initSlow clear request; counters, state and stream flags out.
module anton_neopixel_stream_sequencer
  import anton_neopixel_stream_sequencer_pkg::*;
#(
  parameter  int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter  int RESET_DELAY  = RESET_DELAY_DEFAULT,
  parameter  int SUBBITS      = SUBBITS_DEFAULT,
  localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1),
  localparam int PATTERN_BITS = $clog2(SUBBITS)
) (
  input  logic                    clk6_4mhz,
  input  logic                    reset,
  input  logic                    regCtrlInit,
  input  logic                    regCtrlRun,
  input  logic                    regCtrlLoop,
  input  logic                    regCtrlLimit,
  input  logic                    regCtrl32bit,
  input  logic                    regCtrlRgbw,
  input  logic [LIMIT_W-1:0]      regMax,
  input  logic                    initSlow,
  output logic                    initSlowDone,
  output logic [PATTERN_BITS-1:0] bitPatternIndex,
  output logic [4:0]              pixelBitIndex,
  output logic [BUFFER_BITS-1:0]  pixelIndex,
  output logic [BUFFER_BITS-1:0]  pixelIndexMax,
  output logic [1:0]              state,
  output logic                    streamOutput,
  output logic                    streamReset,
  output logic                    streamBitOf,
  output logic                    streamPixelOf,
  output logic                    streamSyncOf,
  output logic                    streamDone
);

  // The step of 4 must fit even for tiny buffers, so the sum is at least 3 bits.
  localparam int SUM_BITS = (BUFFER_BITS + 1 < 3) ? 3 : BUFFER_BITS + 1;
  localparam logic [PATTERN_BITS-1:0] PATTERN_LAST = PATTERN_BITS'(SUBBITS - 1);
  localparam logic [LIMIT_W-1:0]      END_WIDE     = LIMIT_W'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0]  END_NARROW   = BUFFER_BITS'(BUFFER_END);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_armed;
  logic                    r_rgbw;
  logic                    r_done;
  logic                    r_init_done;
  logic [PATTERN_BITS-1:0] r_pattern;
  logic [4:0]              r_pixel_bit;
  logic [BUFFER_BITS-1:0]  r_pixel_index;

  logic                    w_active;
  logic                    w_start;
  logic                    w_stream_output;
  logic                    w_stream_reset;
  logic                    w_pattern_of;
  logic                    w_bit_of;
  logic                    w_pixel_of;
  logic                    w_sync_of;
  logic                    w_last;
  logic [2:0]              w_step;
  logic [BUFFER_BITS-1:0]  w_index_max;
  logic [SUM_BITS-1:0]     w_index_next;

  assign w_active = regCtrlRun && !regCtrlInit;
  assign w_start  = (r_state == ST_IDLE) && w_active && r_armed;
  assign w_step   = regCtrl32bit ? 3'd4 : 3'd1;

  // Clamp at full 13-bit width so a large regMax is never truncated into range.
  assign w_index_max  = (regCtrlLimit && (regMax <= END_WIDE)) ? regMax[BUFFER_BITS-1:0]
                                                               : END_NARROW;
  assign w_index_next = SUM_BITS'(r_pixel_index) + SUM_BITS'(w_step);
  assign w_last       = w_index_next > SUM_BITS'(w_index_max);

  anton_neopixel_reset_timer #(
    .RESET_DELAY(RESET_DELAY)
  ) u_reset_timer (
    .clk6_4mhz(clk6_4mhz),
    .reset    (reset),
    .clear    (initSlow || w_pixel_of),
    .enable   (w_stream_reset),
    .syncOf   (w_sync_of)
  );

  // State register.
  always_ff @(posedge clk6_4mhz) begin
    if (reset || initSlow) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_start)    w_state_nxt = ST_TRANSMIT;
      ST_TRANSMIT: if (w_pixel_of) w_state_nxt = ST_RESET;
      ST_RESET:    if (w_sync_of)  w_state_nxt = regCtrlLoop ? ST_TRANSMIT : ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // Stream outputs and counter wrap flags.
  always_comb begin
    w_stream_output = w_active && (r_state == ST_TRANSMIT);
    w_stream_reset  = w_active && (r_state == ST_RESET);
    w_pattern_of    = w_stream_output && (r_pattern == PATTERN_LAST);
    w_bit_of        = w_pattern_of && (r_pixel_bit == pixel_bit_last(r_rgbw));
    w_pixel_of      = w_bit_of && w_last;
  end

  always_ff @(posedge clk6_4mhz) begin
    if (reset) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= initSlow;
    end
  end

  always_ff @(posedge clk6_4mhz) begin
    if (reset || initSlow) begin
      r_pattern     <= '0;
      r_pixel_bit   <= '0;
      r_pixel_index <= '0;
      r_armed       <= 1'b1;
      r_rgbw        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_sync_of && !regCtrlLoop;

      // A finished one-shot frame disarms; only Run going low re-arms it.
      if (!regCtrlRun) begin
        r_armed <= 1'b1;
      end else if (w_sync_of && !regCtrlLoop) begin
        r_armed <= 1'b0;
      end

      // Pixel width is sampled only when a frame begins.
      if (w_start || (w_sync_of && regCtrlLoop)) begin
        r_rgbw <= regCtrlRgbw;
      end

      if (w_start) begin
        r_pattern     <= '0;
        r_pixel_bit   <= '0;
        r_pixel_index <= '0;
      end else if (w_stream_output) begin
        r_pattern <= w_pattern_of ? '0 : r_pattern + 1'b1;
        if (w_pattern_of) begin
          r_pixel_bit <= w_bit_of ? 5'd0 : r_pixel_bit + 5'd1;
        end
        if (w_bit_of) begin
          r_pixel_index <= w_last ? '0 : w_index_next[BUFFER_BITS-1:0];
        end
      end
    end
  end

  assign initSlowDone    = r_init_done;
  assign bitPatternIndex = r_pattern;
  assign pixelBitIndex   = r_pixel_bit;
  assign pixelIndex      = r_pixel_index;
  assign pixelIndexMax   = w_index_max;
  assign state           = r_state;
  assign streamOutput    = w_stream_output;
  assign streamReset     = w_stream_reset;
  assign streamBitOf     = w_bit_of;
  assign streamPixelOf   = w_pixel_of;
  assign streamSyncOf    = w_sync_of;
  assign streamDone      = r_done;

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
module tb_anton_neopixel_stream_sequencer;

  localparam int BE = 15;
  localparam int RD = 16;
  localparam int SB = 8;
  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_DATA = 2'd1;
  localparam logic [1:0] K_RST  = 2'd2;

  // One observation per cycle in which the stream is doing something.
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] pix;
    logic [4:0] pbit;
    logic [2:0] pat;
    logic       bit_of;
    logic       pix_of;
    logic       sync_of;
    logic       done;
    logic [3:0] max;
  } rec_t;

  rec_t q[$];
  rec_t mon_act;
  rec_t mon_exp;

  logic        clk = 1'b0;
  logic        reset, regCtrlInit, regCtrlRun, regCtrlLoop, regCtrlLimit;
  logic        regCtrl32bit, regCtrlRgbw, initSlow;
  logic [12:0] regMax;
  logic        initSlowDone, streamOutput, streamReset, streamBitOf;
  logic        streamPixelOf, streamSyncOf, streamDone;
  logic [2:0]  bitPatternIndex;
  logic [4:0]  pixelBitIndex;
  logic [3:0]  pixelIndex, pixelIndexMax;
  logic [1:0]  state;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic loop_mode = 1'b0;
  logic resume_chk = 1'b0;

  always #5 clk = ~clk;

  anton_neopixel_stream_sequencer #(
    .BUFFER_END(BE), .RESET_DELAY(RD), .SUBBITS(SB)
  ) dut (
    .clk6_4mhz(clk), .reset(reset), .regCtrlInit(regCtrlInit), .regCtrlRun(regCtrlRun),
    .regCtrlLoop(regCtrlLoop), .regCtrlLimit(regCtrlLimit), .regCtrl32bit(regCtrl32bit),
    .regCtrlRgbw(regCtrlRgbw), .regMax(regMax), .initSlow(initSlow),
    .initSlowDone(initSlowDone), .bitPatternIndex(bitPatternIndex),
    .pixelBitIndex(pixelBitIndex), .pixelIndex(pixelIndex), .pixelIndexMax(pixelIndexMax),
    .state(state), .streamOutput(streamOutput), .streamReset(streamReset),
    .streamBitOf(streamBitOf), .streamPixelOf(streamPixelOf), .streamSyncOf(streamSyncOf),
    .streamDone(streamDone)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference frame: every pixel from 0 to the effective limit, every bit, every sub-step,
  // then the latch period and (one-shot only) the done pulse.
  task automatic push_frame(input int bpp, input int step, input int emax, input bit with_done);
    rec_t r;
    for (int idx = 0; idx <= emax; idx += step)
      for (int b = 0; b < bpp; b++)
        for (int p = 0; p < SB; p++) begin
          r = '0;
          r.kind   = K_DATA;
          r.pix    = 4'(idx);
          r.pbit   = 5'(b);
          r.pat    = 3'(p);
          r.bit_of = (p == SB - 1) && (b == bpp - 1);
          r.pix_of = r.bit_of && (idx + step > emax);
          r.max    = 4'(emax);
          q.push_back(r);
        end
    for (int k = 0; k < RD; k++) begin
      r = '0;
      r.kind    = K_RST;
      r.sync_of = (k == RD - 1);
      r.max     = 4'(emax);
      q.push_back(r);
    end
    if (with_done) begin
      r = '0;
      r.kind = K_DONE;
      r.done = 1'b1;
      r.max  = 4'(emax);
      q.push_back(r);
    end
  endtask

  task automatic wait_level(input int level, input int budget, input string name);
    int c = 0;
    while (q.size() > level && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(name, 64'(q.size() > level), 64'd0);
    if (q.size() > level) q.delete();
  endtask

  function automatic int eff_max(input bit lim, input int mx);
    if (!lim) return BE;
    return (mx > BE) ? BE : mx;
  endfunction

  task automatic set_mode(input bit rgbw, input bit b32, input bit lim, input int mx);
    regCtrlRgbw  = rgbw;
    regCtrl32bit = b32;
    regCtrlLimit = lim;
    regMax       = 13'(mx);
  endtask

  task automatic arm_and_start();
    regCtrlRun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    regCtrlRun = 1'b1;
    @(posedge clk);
    #1;
    check("start_latency", 64'({state, streamOutput}), 64'({2'd1, 1'b1}));
  endtask

  task automatic run_oneshot(input bit rgbw, input bit b32, input bit lim, input int mx,
                             input int pause_at, input bit pause_init);
    set_mode(rgbw, b32, lim, mx);
    push_frame(rgbw ? 32 : 24, b32 ? 4 : 1, eff_max(lim, mx), 1'b1);
    arm_and_start();
    regCtrlRgbw = ~regCtrlRgbw;  // must not affect a frame in flight
    if (pause_at > 0) begin
      repeat (pause_at) @(posedge clk);
      #1;
      if (pause_init) regCtrlInit = 1'b1;
      else regCtrlRun = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      regCtrlInit = 1'b0;
      regCtrlRun  = 1'b1;
    end
    wait_level(0, q.size() + 100, "frame_drain");
    repeat (20) @(posedge clk);
    #1;
    check("oneshot_no_restart", 64'({state, streamOutput}), 64'd0);
  endtask

  // Monitor: pops an expected observation whenever the stream is active or done pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (resume_chk) begin
        resume_chk = 1'b0;
        if (regCtrlRun && !regCtrlInit)
          check("loop_resume", 64'({streamOutput, pixelIndex}), 64'({1'b1, 4'd0}));
      end
      if (!(regCtrlRun && !regCtrlInit)) begin
        if (q.size() > 0) begin
          check("pause_quiet", 64'({streamOutput, streamReset}), 64'd0);
          if (q[0].kind == K_DATA)
            check("pause_hold", 64'({pixelIndex, pixelBitIndex, bitPatternIndex}),
                  64'({q[0].pix, q[0].pbit, q[0].pat}));
        end
      end else if (streamOutput || streamReset || streamDone) begin
        mon_act.kind    = state;
        mon_act.pix     = pixelIndex;
        mon_act.pbit    = pixelBitIndex;
        mon_act.pat     = bitPatternIndex;
        mon_act.bit_of  = streamBitOf;
        mon_act.pix_of  = streamPixelOf;
        mon_act.sync_of = streamSyncOf;
        mon_act.done    = streamDone;
        mon_act.max     = pixelIndexMax;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no activity", mon_act);
        end else begin
          mon_exp = q.pop_front();
          check("stream", 64'(mon_act), 64'(mon_exp));
          if (mon_exp.sync_of && loop_mode) resume_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    int emax;
    int flen;
    reset = 1'b1; regCtrlInit = 1'b0; regCtrlRun = 1'b0; regCtrlLoop = 1'b0;
    regCtrlLimit = 1'b0; regCtrl32bit = 1'b0; regCtrlRgbw = 1'b0; regMax = '0; initSlow = 1'b0;
    regCtrlRun = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({state, pixelIndex, pixelBitIndex, bitPatternIndex, streamOutput,
                             streamReset, streamDone, initSlowDone}), 64'd0);
    regCtrlRun = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", 64'({state, streamOutput, streamReset, streamDone}), 64'd0);

    // Directed frames: short RGB, RGBW, stride-4 limited, clamped limit, full RGBW buffer.
    run_oneshot(1'b0, 1'b0, 1'b1, 3, 0, 1'b0);
    run_oneshot(1'b1, 1'b0, 1'b1, 1, 300, 1'b0);
    run_oneshot(1'b0, 1'b1, 1'b1, 8, 100, 1'b1);
    run_oneshot(1'b0, 1'b1, 1'b1, 100, 0, 1'b0);
    run_oneshot(1'b1, 1'b0, 1'b0, 0, 700, 1'b0);
    // Random frames.
    for (int f = 0; f < 4; f++)
      run_oneshot(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 150)), 1'($urandom));

    // Loop mode: three complete frames back to back, then initSlow inside the fourth.
    loop_mode = 1'b1;
    regCtrlLoop = 1'b1;
    set_mode(1'($urandom), 1'b0, 1'b1, int'($urandom_range(0, 3)));
    emax = eff_max(1'b1, int'(regMax));
    flen = (emax + 1) * (regCtrlRgbw ? 32 : 24) * SB + RD;
    for (int f = 0; f < 4; f++) push_frame(regCtrlRgbw ? 32 : 24, 1, emax, 1'b0);
    arm_and_start();
    wait_level(flen - 60, 4 * flen + 100, "loop_progress");
    q.delete();
    regCtrlRun = 1'b0;
    initSlow = 1'b1;
    @(posedge clk);
    #1;
    initSlow = 1'b0;
    check("init_slow_clear", 64'({state, pixelIndex, pixelBitIndex, bitPatternIndex, initSlowDone}),
          64'({2'd0, 4'd0, 5'd0, 3'd0, 1'b1}));
    @(posedge clk);
    #1;
    check("init_done_pulse", 64'(initSlowDone), 64'd0);
    loop_mode = 1'b0;
    regCtrlLoop = 1'b0;

    // Synchronous reset while in the latch period.
    set_mode(1'b0, 1'b0, 1'b1, 0);
    push_frame(24, 1, 0, 1'b1);
    arm_and_start();
    wait_level(10, 400, "reach_latch");
    q.delete();
    reset = 1'b1;
    regCtrlRun = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_latch", 64'({state, pixelIndex, pixelBitIndex, bitPatternIndex, streamReset,
                                 streamDone}), 64'd0);
    reset = 1'b0;

    // Recovery frame: latch period must again be exactly RD cycles.
    run_oneshot(1'b0, 1'b0, 1'b1, 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
